// File: rtl/dummy_sink_checker.sv
// dummy_sink_checker: AXI4-Stream sink that applies a TREADY backpressure
// pattern and checks an incrementing per-lane data pattern, TSTRB and packet length.
//
// Ports:
//   s00_axis_aclk, s00_axis_aresetn : clock, async active-low reset
//   enable, clear, seed             : run level, sync clear pulse, start value
//   s00_axis_t*                     : AXI4-Stream slave (tready is registered)
//   beat_count, pkt_count, err_count: saturating statistics
//   first_err_beat, err, done       : first error position, sticky flags
module dummy_sink_checker #(
    parameter int C_S00_AXIS_TDATA_WIDTH = 64,
    parameter int C_READY_MODE           = 0,
    parameter int C_READY_ON             = 3,
    parameter int C_READY_OFF            = 1,
    parameter int C_PKT_LEN              = 16,
    parameter int C_NUM_PKTS             = 0,
    parameter int C_CNT_WIDTH            = 32
) (
    input  logic                                s00_axis_aclk,
    input  logic                                s00_axis_aresetn,
    input  logic                                enable,
    input  logic                                clear,
    input  logic [31:0]                         seed,
    output logic                                s00_axis_tready,
    input  logic [C_S00_AXIS_TDATA_WIDTH-1:0]   s00_axis_tdata,
    input  logic [C_S00_AXIS_TDATA_WIDTH/8-1:0] s00_axis_tstrb,
    input  logic                                s00_axis_tlast,
    input  logic                                s00_axis_tvalid,
    output logic [C_CNT_WIDTH-1:0]              beat_count,
    output logic [C_CNT_WIDTH-1:0]              pkt_count,
    output logic [C_CNT_WIDTH-1:0]              err_count,
    output logic [C_CNT_WIDTH-1:0]              first_err_beat,
    output logic                                err,
    output logic                                done
);

    localparam int N    = C_S00_AXIS_TDATA_WIDTH / 32;
    localparam int SW   = C_S00_AXIS_TDATA_WIDTH / 8;
    localparam int CW   = C_CNT_WIDTH;
    localparam int IW   = (C_PKT_LEN > 1) ? $clog2(C_PKT_LEN) : 1;
    localparam int PMAX = (C_READY_ON > C_READY_OFF) ? C_READY_ON : C_READY_OFF;
    localparam int PW   = (PMAX > 1) ? $clog2(PMAX) + 1 : 1;

    localparam logic [IW-1:0] LAST_IDX = IW'(C_PKT_LEN - 1);
    localparam logic [PW-1:0] ON_LAST  = PW'(C_READY_ON - 1);
    localparam logic [PW-1:0] OFF_LAST = PW'((C_READY_OFF > 0) ? C_READY_OFF - 1 : 0);
    localparam logic [CW-1:0] NUM_PKTS = CW'(C_NUM_PKTS);
    localparam logic [31:0]   STEP     = 32'(N);

    // Duty-cycle mode with a zero OFF time degenerates to always-ready.
    localparam bit USE_DUTY = (C_READY_MODE == 1) && (C_READY_OFF > 0);
    localparam bit USE_RAND = (C_READY_MODE == 2);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ON   = 2'd1,
        S_OFF  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t        state, state_n;
    logic [PW-1:0] phase;
    logic [31:0]   lfsr;
    logic [31:0]   expected;
    logic [IW-1:0] idx;

    logic          accept;
    logic          data_err;
    logic          strb_err;
    logic          len_err;
    logic          beat_err;
    logic          at_last;
    logic          done_hit;
    logic [CW-1:0] pkt_next;
    logic          lfsr_fb;

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (&v) ? v : v + CW'(1);
    endfunction

    // x^32 + x^22 + x^2 + x + 1
    assign lfsr_fb = lfsr[31] ^ lfsr[21] ^ lfsr[1] ^ lfsr[0];

    always_comb begin
        s00_axis_tready = 1'b0;
        if (state == S_ON) begin
            s00_axis_tready = USE_RAND ? lfsr[0] : 1'b1;
        end
    end

    assign accept   = s00_axis_tvalid & s00_axis_tready;
    assign strb_err = (s00_axis_tstrb != {SW{1'b1}});
    assign at_last  = (idx == LAST_IDX);
    assign len_err  = (s00_axis_tlast != at_last);
    assign beat_err = data_err | strb_err | len_err;
    assign pkt_next = sat_inc(pkt_count);
    assign done_hit = (C_NUM_PKTS != 0) && accept && s00_axis_tlast
                      && (pkt_next == NUM_PKTS);

    always_comb begin
        data_err = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (s00_axis_tdata[i*32 +: 32] != expected + 32'(i)) begin
                data_err = 1'b1;
            end
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE: begin
                if (enable) state_n = S_ON;
            end
            S_ON: begin
                if (!enable) state_n = S_IDLE;
                else if (USE_DUTY && phase == ON_LAST) state_n = S_OFF;
            end
            S_OFF: begin
                if (!enable) state_n = S_IDLE;
                else if (phase == OFF_LAST) state_n = S_ON;
            end
            S_DONE: state_n = S_DONE;
            default: state_n = S_IDLE;
        endcase
        if (done_hit) state_n = S_DONE;
        if (clear) state_n = S_IDLE;
    end

    always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
        if (!s00_axis_aresetn) begin
            state <= S_IDLE;
            phase <= '0;
            lfsr  <= 32'h1;
        end else begin
            state <= state_n;
            if (clear) begin
                phase <= '0;
                lfsr  <= 32'h1;
            end else begin
                if (state_n != state) begin
                    phase <= '0;
                end else if (USE_DUTY && (state == S_ON || state == S_OFF)) begin
                    phase <= phase + PW'(1);
                end
                if (state == S_ON) begin
                    lfsr <= {lfsr[30:0], lfsr_fb};
                end
            end
        end
    end

    always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
        if (!s00_axis_aresetn) begin
            expected       <= '0;
            idx            <= '0;
            beat_count     <= '0;
            pkt_count      <= '0;
            err_count      <= '0;
            first_err_beat <= '0;
            err            <= 1'b0;
            done           <= 1'b0;
        end else if (clear) begin
            expected       <= '0;
            idx            <= '0;
            beat_count     <= '0;
            pkt_count      <= '0;
            err_count      <= '0;
            first_err_beat <= '0;
            err            <= 1'b0;
            done           <= 1'b0;
        end else begin
            if (state == S_IDLE && enable) begin
                expected <= seed;
            end
            if (accept) begin
                expected   <= expected + STEP;
                beat_count <= sat_inc(beat_count);
                // A missing TLAST at the final index still closes the packet.
                if (s00_axis_tlast || at_last) idx <= '0;
                else idx <= idx + IW'(1);
                if (s00_axis_tlast) pkt_count <= pkt_next;
                if (beat_err) begin
                    err_count <= sat_inc(err_count);
                    err       <= 1'b1;
                    if (!err) first_err_beat <= beat_count;
                end
            end
            if (done_hit) done <= 1'b1;
        end
    end

endmodule
